// File: rtl/seq_pkg.sv
// Shared definitions for the serializer feeder and the downstream "110" sequence detector.
package seq_pkg;

    localparam int unsigned SER_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    // Detector progress through the "110" pattern
    typedef enum logic [1:0] {
        DET_S0  = 2'd0,
        DET_S1  = 2'd1,
        DET_S11 = 2'd2
    } det_state_t;

    function automatic logic even_parity(input logic [31:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// Valid/ready word-to-bit serializer with zero-gap streaming between words.
// Optional trailing even-parity bit per word when SER_PARITY_EN is defined.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH     = SER_DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             word_done
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] shifted_c;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             word_done_q, word_done_d;
    logic             ready_c;
    logic             accept_c;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    // The bit on the wire is always the head of the shift register.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign shifted_c = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sreg_d      = sreg_q;
        bit_out_d   = 1'b0;
        bit_valid_d = 1'b0;
        word_done_d = 1'b0;
        ready_c     = 1'b0;
`ifdef SER_PARITY_EN
        par_d       = par_q;
`endif

        // Ready only when the cycle after the next edge has no bit of the current word left
        case (state_q)
            IDLE:    ready_c = 1'b1;
`ifdef SER_PARITY_EN
            SHIFT:   ready_c = 1'b0;
            PARITY:  ready_c = 1'b1;
`else
            SHIFT:   ready_c = (cnt_q == '0);
`endif
            default: ready_c = 1'b0;
        endcase
        accept_c = ready_c & s_valid;

        if (state_q == SHIFT && cnt_q != '0) begin
            cnt_d       = cnt_q - CNT_W'(1);
            sreg_d      = shifted_c;
            bit_out_d   = head(shifted_c);
            bit_valid_d = 1'b1;
`ifndef SER_PARITY_EN
            word_done_d = (cnt_q == CNT_W'(1));
`endif
        end
`ifdef SER_PARITY_EN
        else if (state_q == SHIFT) begin
            state_d     = PARITY;
            bit_out_d   = par_q;
            bit_valid_d = 1'b1;
            word_done_d = 1'b1;
        end
`endif
        else if (accept_c) begin
            state_d     = SHIFT;
            cnt_d       = CNT_LAST;
            sreg_d      = s_data;
            bit_out_d   = head(s_data);
            bit_valid_d = 1'b1;
`ifdef SER_PARITY_EN
            par_d       = even_parity(32'(s_data));
`endif
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sreg_q      <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            word_done_q <= 1'b0;
`ifdef SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sreg_q      <= sreg_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            word_done_q <= word_done_d;
`ifdef SER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign s_ready   = ready_c & ~rst;
    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign word_done = word_done_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Randomized bench for seq_bit_serializer: MSB-first and LSB-first instances checked
// against a queue of expected (bit, done) pairs built from each accepted word.
module tb_seq_bit_serializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready, bit_out, bit_valid, word_done;
    logic         l_ready, l_bit, l_valid, l_done;

    int   n_checks = 0;
    int   n_fails  = 0;
    logic last_acc = 1'b0;

    // Each entry is {bit, word_done}
    logic [1:0] q_msb[$];
    logic [1:0] q_lsb[$];

    always #5 clk = ~clk;

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .bit_out(bit_out), .bit_valid(bit_valid), .word_done(word_done)
    );

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(l_ready),
        .bit_out(l_bit), .bit_valid(l_valid), .word_done(l_done)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
`ifdef SER_PARITY_EN
            q_msb.push_back({w[W-1-i], 1'b0});
            q_lsb.push_back({w[i], 1'b0});
`else
            q_msb.push_back({w[W-1-i], logic'(i == W - 1)});
            q_lsb.push_back({w[i], logic'(i == W - 1)});
`endif
        end
`ifdef SER_PARITY_EN
        q_msb.push_back({^w, 1'b1});
        q_lsb.push_back({^w, 1'b1});
`endif
    endtask

    task automatic check_outputs();
        logic exp_v;
        exp_v = (q_msb.size() != 0);
        check("msb bit_valid", bit_valid, exp_v);
        check("lsb bit_valid", l_valid, exp_v);
        if (exp_v) begin
            check("msb bit_out", bit_out, q_msb[0][1]);
            check("msb word_done", word_done, q_msb[0][0]);
            check("lsb bit_out", l_bit, q_lsb[0][1]);
            check("lsb word_done", l_done, q_lsb[0][0]);
        end else begin
            check("msb idle bit_out", bit_out, 1'b0);
            check("msb idle word_done", word_done, 1'b0);
            check("lsb idle bit_out", l_bit, 1'b0);
            check("lsb idle word_done", l_done, 1'b0);
        end
        check("msb s_ready", s_ready, logic'(q_msb.size() <= 1));
        check("lsb s_ready", l_ready, logic'(q_msb.size() <= 1));
    endtask

    // One clock: check outputs away from the edge, drive inputs, then advance the model.
    task automatic step(input logic v, input logic [W-1:0] d);
        logic acc;
        @(negedge clk);
        check_outputs();
        s_valid = v;
        s_data  = d;
        acc     = v && (q_msb.size() <= 1);
        @(posedge clk);
        if (q_msb.size() != 0) begin
            void'(q_msb.pop_front());
            void'(q_lsb.pop_front());
        end
        if (acc) push_word(d);
        last_acc = acc;
    endtask

    initial begin
        int           pct;
        logic         v;
        logic [W-1:0] d;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset s_ready", s_ready, 1'b0);
        check("reset bit_valid", bit_valid, 1'b0);
        check("reset bit_out", bit_out, 1'b0);
        check("reset word_done", word_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, '0);

        // Single word 0xDA: 1,1,0,1,1,0,1,0 MSB-first
        step(1'b1, 8'hDA);
        repeat (10) step(1'b0, W'($urandom));

        // Back-to-back 0x03 then 0x00 with s_valid held high
        step(1'b1, 8'h03);
        for (int k = 0; k < 20 && !last_acc; k++) step(1'b1, 8'h00);
        check("b2b second word accepted", last_acc, 1'b1);
        repeat (12) step(1'b0, '0);

        // Reset in the middle of 0xFF
        step(1'b1, 8'hFF);
        repeat (4) step(1'b0, '0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midword rst bit_valid", bit_valid, 1'b0);
        check("midword rst bit_out", bit_out, 1'b0);
        check("midword rst word_done", word_done, 1'b0);
        check("midword rst s_ready", s_ready, 1'b0);
        q_msb.delete();
        q_lsb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(1'b0, '0);

        // Random traffic with phases of varying s_valid density
        d = W'($urandom);
        v = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            case ((c / 200) % 4)
                0:       pct = 100;
                1:       pct = 70;
                2:       pct = 30;
                default: pct = 90;
            endcase
            if (!(v && !last_acc && $urandom_range(99) < 75)) d = W'($urandom);
            v = ($urandom_range(99) < pct);
            step(v, d);
        end
        repeat (12) step(1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
